// File: rtl/pic_in_service_pkg.sv
// Shared definitions for the PIC in-service tracking block.
package pic_in_service_pkg;

    // Default number of request lines / ISR bits (bit 0 = highest priority).
    localparam int unsigned NUM_IRQ_DEFAULT = 8;

    // Width of an index into an n-bit request vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pic_in_service_priority_encoder.sv
// Lowest-set-bit finder: reports the index of the lowest-numbered set bit and whether any is set.
module pic_in_service_priority_encoder
    import pic_in_service_pkg::*;
#(
    parameter int unsigned N = NUM_IRQ_DEFAULT,
    localparam int unsigned IdxW = idx_width(N)
) (
    input  logic [N-1:0]    vec,
    output logic [IdxW-1:0] index,
    output logic            valid
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IdxW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_in_service.sv
// In-service register for an 8259A-style PIC in fully nested mode: latches request edges into a
// pending set, grants the highest-priority candidate when it outranks every in-service level,
// and retires the highest-priority in-service level on each non-specific EOI rising edge.
module pic_in_service
    import pic_in_service_pkg::*;
#(
    parameter int unsigned NUM_IRQ = NUM_IRQ_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] interrupt_request,
    input  logic               end_of_interrupt,
    output logic [NUM_IRQ-1:0] in_service_interrupt
);

    localparam int unsigned IdxW = idx_width(NUM_IRQ);

    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [NUM_IRQ-1:0] req_prev_q;
    logic               eoi_prev_q;

    logic [NUM_IRQ-1:0] req_edge;
    logic [NUM_IRQ-1:0] cand;
    logic               eoi_pulse;
    logic [NUM_IRQ-1:0] eoi_clear;
    logic [NUM_IRQ-1:0] isr_eff;
    logic               grant;
    logic [NUM_IRQ-1:0] grant_onehot;

    logic [IdxW-1:0]    isr_idx;
    logic               isr_valid;
    logic [IdxW-1:0]    cand_idx;
    logic               cand_valid;
    logic [IdxW-1:0]    eff_idx;
    logic               eff_valid;

    // Highest-priority level currently in service: the one a non-specific EOI retires.
    pic_in_service_priority_encoder #(
        .N(NUM_IRQ)
    ) u_isr_enc (
        .vec  (isr_q),
        .index(isr_idx),
        .valid(isr_valid)
    );

    // Highest-priority grant candidate.
    pic_in_service_priority_encoder #(
        .N(NUM_IRQ)
    ) u_cand_enc (
        .vec  (cand),
        .index(cand_idx),
        .valid(cand_valid)
    );

    // Highest-priority level still in service after this cycle's EOI.
    pic_in_service_priority_encoder #(
        .N(NUM_IRQ)
    ) u_eff_enc (
        .vec  (isr_eff),
        .index(eff_idx),
        .valid(eff_valid)
    );

    // Edge detection, EOI retirement and the nested-mode grant decision.
    always_comb begin
        req_edge     = interrupt_request & ~req_prev_q;
        cand         = pending_q | req_edge;
        eoi_pulse    = end_of_interrupt & ~eoi_prev_q;
        eoi_clear    = '0;
        if (eoi_pulse && isr_valid) begin
            eoi_clear = NUM_IRQ'(1) << isr_idx;
        end
        // EOI takes effect before the grant so a retired level can be replaced at the same edge.
        isr_eff      = isr_q & ~eoi_clear;
        // Grant only when the candidate strictly outranks every remaining in-service level.
        grant        = cand_valid && (!eff_valid || (cand_idx < eff_idx));
        grant_onehot = '0;
        if (grant) begin
            grant_onehot = NUM_IRQ'(1) << cand_idx;
        end
        isr_d        = isr_eff | grant_onehot;
        pending_d    = cand & ~grant_onehot;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q  <= '0;
            isr_q      <= '0;
            req_prev_q <= '0;
            eoi_prev_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            isr_q      <= isr_d;
            req_prev_q <= interrupt_request;
            eoi_prev_q <= end_of_interrupt;
        end
    end

    assign in_service_interrupt = isr_q;

endmodule

// File: tb/tb_pic_in_service.sv
// Bench for pic_in_service: a table of directed multi-cycle sequences followed by randomized
// traffic checked against a stack-based model of fully nested interrupt servicing.
module tb_pic_in_service;

    logic       clock;
    logic       reset;
    logic [7:0] interrupt_request;
    logic       end_of_interrupt;
    logic [7:0] in_service_interrupt;

    int n_cmp;
    int n_bad;

    pic_in_service #(
        .NUM_IRQ(8)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .interrupt_request   (interrupt_request),
        .end_of_interrupt    (end_of_interrupt),
        .in_service_interrupt(in_service_interrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic       eoi;
        logic [7:0] exp_isr;
    } vec_t;

    vec_t tbl[$];

    // Model: in-service levels form a stack (front = highest priority), pending is a set.
    bit [7:0] m_prev;
    bit       m_eoi_prev;
    bit       m_pend[8];
    int       m_stack[$];

    task automatic add(input logic r, input logic [7:0] i, input logic e, input logic [7:0] x);
        vec_t v;
        v.rst = r;
        v.irq = i;
        v.eoi = e;
        v.exp_isr = x;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: ISR got %h, expected %h", name, got, want);
        end
    endtask

    // Apply one cycle of inputs and sample just after the active edge.
    task automatic apply(input logic r, input logic [7:0] i, input logic e);
        reset = r;
        interrupt_request = i;
        end_of_interrupt = e;
        @(posedge clock);
        #1;
    endtask

    task automatic model_step(input logic r, input logic [7:0] i, input logic e);
        int p;
        if (r) begin
            m_prev = '0;
            m_eoi_prev = 1'b0;
            for (int k = 0; k < 8; k++) m_pend[k] = 1'b0;
            m_stack.delete();
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (i[k] && !m_prev[k]) m_pend[k] = 1'b1;
            end
            if (e && !m_eoi_prev && m_stack.size() > 0) void'(m_stack.pop_front());
            p = -1;
            for (int k = 7; k >= 0; k--) begin
                if (m_pend[k]) p = k;
            end
            if (p >= 0 && (m_stack.size() == 0 || p < m_stack[0])) begin
                m_stack.push_front(p);
                m_pend[p] = 1'b0;
            end
            m_prev = i;
            m_eoi_prev = e;
        end
    endtask

    function automatic logic [7:0] model_isr();
        logic [7:0] v;
        v = '0;
        foreach (m_stack[k]) v[m_stack[k]] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [7:0] irq;
        logic       eoi;
        logic       rst;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        interrupt_request = '0;
        end_of_interrupt = 1'b0;

        // Single request held high through reset release.
        add(1, 8'h01, 0, 8'h00);
        add(0, 8'h01, 0, 8'h01);
        add(0, 8'h01, 0, 8'h01);
        // Three simultaneous edges; a long EOI retires only one level.
        add(1, 8'h07, 0, 8'h00);
        add(0, 8'h07, 0, 8'h01);
        add(0, 8'h00, 1, 8'h02);
        add(0, 8'h00, 1, 8'h02);
        add(0, 8'h00, 0, 8'h02);
        add(0, 8'h00, 1, 8'h04);
        add(0, 8'h00, 0, 8'h04);
        add(0, 8'h00, 1, 8'h00);
        // Nesting: IRQ1 preempts IRQ3, IRQ5 waits until both retire.
        add(1, 8'h00, 0, 8'h00);
        add(0, 8'h08, 0, 8'h08);
        add(0, 8'h0A, 0, 8'h0A);
        add(0, 8'h2A, 0, 8'h0A);
        add(0, 8'h00, 1, 8'h08);
        add(0, 8'h00, 0, 8'h08);
        add(0, 8'h00, 1, 8'h20);
        add(0, 8'h00, 0, 8'h20);
        add(0, 8'h00, 1, 8'h00);
        // Held request is not re-granted until it goes low and high again.
        add(1, 8'h00, 0, 8'h00);
        add(0, 8'h04, 0, 8'h04);
        add(0, 8'h04, 1, 8'h00);
        add(0, 8'h04, 0, 8'h00);
        add(0, 8'h00, 0, 8'h00);
        add(0, 8'h04, 0, 8'h04);
        // EOI and a new IRQ0 edge at the same edge.
        add(0, 8'h05, 1, 8'h01);
        // Reset mid-operation with IRQ5 pending.
        add(1, 8'h00, 0, 8'h00);
        add(0, 8'h08, 0, 8'h08);
        add(0, 8'h0A, 0, 8'h0A);
        add(0, 8'h2A, 0, 8'h0A);
        add(1, 8'h00, 0, 8'h00);
        add(0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 0, 8'h00);
        add(0, 8'h02, 0, 8'h02);
        // Line held high across reset re-triggers at release.
        add(1, 8'h02, 0, 8'h00);
        add(0, 8'h02, 0, 8'h02);

        foreach (tbl[k]) begin
            apply(tbl[k].rst, tbl[k].irq, tbl[k].eoi);
            check($sformatf("vec%0d", k), in_service_interrupt, tbl[k].exp_isr);
        end

        // Randomized traffic against the model.
        model_step(1'b1, 8'h00, 1'b0);
        apply(1'b1, 8'h00, 1'b0);
        check("rand_reset", in_service_interrupt, model_isr());
        irq = '0;
        for (int c = 0; c < 3000; c++) begin
            irq = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            eoi = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 149) == 0);
            model_step(rst, irq, eoi);
            apply(rst, irq, eoi);
            check($sformatf("rand%0d", c), in_service_interrupt, model_isr());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
